preescaler_multicanal: RTL and testbench
========================================

# preescaler_multicanal

Multi-channel, run-time programmable clock prescaler, successor to the fixed single-output divider. It produces CANALES independent clock-enable ticks and optional square-wave outputs from the system clock `clkMhz`. Each channel's divisor and mode can be reprogrammed over a simple write port without glitches. It sits between the system clock and slow peripherals (displays, UART baud, debounce, PWM bases).

## Interface
Parameters:
- CANALES, 4, number of independent channels (1..16)
- ANCHO, 26, counter/divisor width in bits
- CH_BITS, 2, channel index width; 2**CH_BITS >= CANALES
- DIV_INICIAL, 50000, divisor loaded into every channel at reset (1 .. 2**ANCHO-1)

Ports:
- clkMhz  in  1  system clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- en  in  1  global count enable
- sync  in  1  synchronous restart of all channels
- wr_en  in  1  write strobe, one cycle per write
- wr_ch  in  CH_BITS  target channel
- wr_div  in  ANCHO  new divisor
- wr_modo  in  1  new mode: 0 = pulse, 1 = square
- tick  out  CANALES  one-cycle clock-enable per channel, registered
- clk_out  out  CANALES  square wave per channel, registered
- wr_err  out  1  one-cycle flag, write rejected

## Operation
- Per-channel state:
  - cnt[ANCHO]
  - active div/modo
  - pending div/modo with a pend valid bit
- Reset values:
  - cnt = 0, div = DIV_INICIAL, modo = 0, pend = 0
  - tick = 0, clk_out = 0, wr_err = 0
- Counting, en=1, sync=0:
  - If cnt == div-1: cnt <= 0 and tick[i] <= 1. In square mode, clk_out[i] toggles.
  - Otherwise: cnt <= cnt+1 and tick[i] <= 0.
- en=0: cnt and clk_out hold, tick <= 0. Pending writes stay pending.
- div = 1: tick is held high every cycle while enabled. clk_out toggles every cycle in square mode.
- Write handling:
  - A write is rejected when wr_ch >= CANALES or wr_div == 0. Rejection sets wr_err <= 1 for one cycle and changes no state.
  - An accepted write loads pending div/modo and sets pend. A later write before the wrap overwrites pending (last write wins).
- Apply rule:
  - At the wrap edge (cnt == div-1, en=1) with pend=1, the active div/modo take the pending values and pend clears.
  - The pending value used is the one stored before that edge. A write in the same cycle becomes pending for the next wrap.
  - If the newly applied modo is 0, clk_out[i] <= 0 at that edge.
- sync=1, highest priority after rst:
  - All cnt <= 0, tick <= 0, clk_out <= 0.
  - Every pending div/modo is applied and pend clears.
  - A write accepted in the same cycle goes directly to the active registers.
- Pulse mode: clk_out[i] stays 0.
- Channels never interact except through en, sync and rst.

## Timing
- Latency: tick is registered. It is high during the cycle after the edge at which cnt == div-1.
- After rst deasserts, or after a sync cycle, with en=1 continuously: the first tick is high after div rising edges. Period is div cycles, high for 1 cycle.
- Square mode: clk_out period is 2·div cycles and edges are aligned with tick assertion. There is no glitch or short phase on a divisor change, because the change applies only at a wrap.
- wr_err is high in the cycle after the rejected wr_en edge.
- rst asserted mid-count forces all outputs to their reset values immediately (asynchronous). Counting resumes on the first clkMhz edge after release.
- Counter never exceeds div-1, because div changes only when cnt == 0 is next.

## Test plan
- Reset, en=1, DIV_INICIAL=5, CANALES=4 -> every tick high 1 cycle in 5, first at the 5th edge after release, all clk_out = 0.
- Write ch1 div=3 modo=1 mid-count -> ch1 keeps period 5 until its next wrap, then tick period 3 and clk_out period 6, 50% duty. Other channels unchanged.
- Writes with wr_ch=5 (CANALES=4) and wr_div=0 -> wr_err pulses for 1 cycle each, with no change in periods.
- div=1 on ch0, en toggled 0 for 3 cycles -> tick continuous while en=1, 0 during en=0, cnt held, no extra or missing wrap on resume.
- Pending write to ch2, then sync in the same cycle as a write to ch3 -> all counters restart at 0, ch2 and ch3 use new values from the next cycle, first ticks after their new div.
- rst asserted asynchronously mid-period in square mode -> tick/clk_out/wr_err drop to 0 without a clock, divisors return to DIV_INICIAL, pending cleared.

Source files
------------

// File: rtl/preescaler_multicanal.sv
// Multi-channel run-time programmable prescaler: per-channel clock-enable ticks
// and square waves, with divisor/mode changes deferred to the channel's wrap.
module preescaler_multicanal #(
    parameter int unsigned CANALES     = 4,
    parameter int unsigned ANCHO       = 26,
    parameter int unsigned CH_BITS     = 2,
    parameter int unsigned DIV_INICIAL = 50000
) (
    input  logic               clkMhz,
    input  logic               rst,
    input  logic               en,
    input  logic               sync,
    input  logic               wr_en,
    input  logic [CH_BITS-1:0] wr_ch,
    input  logic [ANCHO-1:0]   wr_div,
    input  logic               wr_modo,
    output logic [CANALES-1:0] tick,
    output logic [CANALES-1:0] clk_out,
    output logic               wr_err
);

    logic [ANCHO-1:0]   cnt_q  [CANALES];
    logic [ANCHO-1:0]   cnt_d  [CANALES];
    logic [ANCHO-1:0]   div_q  [CANALES];
    logic [ANCHO-1:0]   div_d  [CANALES];
    logic [ANCHO-1:0]   pdiv_q [CANALES];
    logic [ANCHO-1:0]   pdiv_d [CANALES];
    logic [CANALES-1:0] modo_q, modo_d;
    logic [CANALES-1:0] pmodo_q, pmodo_d;
    logic [CANALES-1:0] pend_q, pend_d;
    logic [CANALES-1:0] tick_q, tick_d;
    logic [CANALES-1:0] clk_q, clk_d;
    logic               wr_err_q, wr_err_d;

    logic               wr_ok_c;
    logic [CANALES-1:0] hit_c;

    // Write validation and per-channel decode
    always_comb begin
        wr_ok_c = wr_en && (32'(wr_ch) < CANALES) && (wr_div != '0);
        hit_c   = '0;
        for (int i = 0; i < CANALES; i++) begin
            hit_c[i] = wr_ok_c && (wr_ch == CH_BITS'(i));
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        pdiv_d   = pdiv_q;
        modo_d   = modo_q;
        pmodo_d  = pmodo_q;
        pend_d   = pend_q;
        tick_d   = '0;
        clk_d    = clk_q;
        wr_err_d = wr_en && !wr_ok_c;
        for (int i = 0; i < CANALES; i++) begin
            if (sync) begin
                // Restart: flush pending, a same-cycle write lands directly in active
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
                pend_d[i] = 1'b0;
                if (pend_q[i]) begin
                    div_d[i]  = pdiv_q[i];
                    modo_d[i] = pmodo_q[i];
                end
                if (hit_c[i]) begin
                    div_d[i]  = wr_div;
                    modo_d[i] = wr_modo;
                end
            end else begin
                if (en) begin
                    if (cnt_q[i] == div_q[i] - ANCHO'(1)) begin
                        cnt_d[i]  = '0;
                        tick_d[i] = 1'b1;
                        if (pend_q[i]) begin
                            div_d[i]  = pdiv_q[i];
                            modo_d[i] = pmodo_q[i];
                            pend_d[i] = 1'b0;
                        end
                        clk_d[i] = modo_d[i] ? ~clk_q[i] : 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + ANCHO'(1);
                    end
                end
                // Written after the apply so a same-cycle write waits for the next wrap
                if (hit_c[i]) begin
                    pdiv_d[i]  = wr_div;
                    pmodo_d[i] = wr_modo;
                    pend_d[i]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clkMhz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CANALES; i++) begin
                cnt_q[i]  <= '0;
                div_q[i]  <= ANCHO'(DIV_INICIAL);
                pdiv_q[i] <= ANCHO'(DIV_INICIAL);
            end
            modo_q   <= '0;
            pmodo_q  <= '0;
            pend_q   <= '0;
            tick_q   <= '0;
            clk_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            pdiv_q   <= pdiv_d;
            modo_q   <= modo_d;
            pmodo_q  <= pmodo_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            clk_q    <= clk_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_q;
    assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_preescaler_multicanal.sv
// Directed bench for preescaler_multicanal: 4 channels, reset divisor 5,
// expected tick/clk_out/wr_err values worked out by hand per clock edge.
module tb_preescaler_multicanal;

    localparam int unsigned CANALES     = 4;
    localparam int unsigned ANCHO       = 8;
    localparam int unsigned CH_BITS     = 3;
    localparam int unsigned DIV_INICIAL = 5;

    logic               clkMhz;
    logic               rst;
    logic               en;
    logic               sync;
    logic               wr_en;
    logic [CH_BITS-1:0] wr_ch;
    logic [ANCHO-1:0]   wr_div;
    logic               wr_modo;
    logic [CANALES-1:0] tick;
    logic [CANALES-1:0] clk_out;
    logic               wr_err;

    int checks = 0;
    int errors = 0;

    preescaler_multicanal #(
        .CANALES    (CANALES),
        .ANCHO      (ANCHO),
        .CH_BITS    (CH_BITS),
        .DIV_INICIAL(DIV_INICIAL)
    ) dut (
        .clkMhz (clkMhz),
        .rst    (rst),
        .en     (en),
        .sync   (sync),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .wr_modo(wr_modo),
        .tick   (tick),
        .clk_out(clk_out),
        .wr_err (wr_err)
    );

    initial begin
        clkMhz = 1'b0;
        forever #5 clkMhz = ~clkMhz;
    end

    task automatic step();
        @(posedge clkMhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] t, input logic [3:0] c);
        chk({tag, ".tick"}, 32'(tick), 32'(t));
        chk({tag, ".clk_out"}, 32'(clk_out), 32'(c));
    endtask

    task automatic wr(input int ch, input int dv, input logic m);
        wr_en   = 1'b1;
        wr_ch   = CH_BITS'(ch);
        wr_div  = ANCHO'(dv);
        wr_modo = m;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; sync = 1'b0;
        wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_modo = 1'b0;
        step(); step();
        chk_out("reset", 4'h0, 4'h0);
        chk("reset.wr_err", 32'(wr_err), 32'd0);
        rst = 1'b0;

        // Default divisor 5: first tick at the 5th edge after release
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("startup.tick", 32'(tick), 32'd0);
        end
        step(); chk_out("e5", 4'hf, 4'h0);
        step(); chk_out("e6", 4'h0, 4'h0);

        // ch1 -> div 3 square, applied at its next wrap (edge 10)
        wr(1, 3, 1'b1);
        step(); chk_out("e7", 4'h0, 4'h0);
        chk("e7.wr_err", 32'(wr_err), 32'd0);
        wr_en = 1'b0;
        step(); step();
        step(); chk_out("e10", 4'hf, 4'h2);
        step(); chk_out("e11", 4'h0, 4'h2);
        step(); step(); chk_out("e13", 4'h2, 4'h0);
        step(); step(); chk_out("e15", 4'hd, 4'h0);
        step(); chk_out("e16", 4'h2, 4'h2);

        // Rejected writes: channel out of range, zero divisor
        wr(5, 2, 1'b0);
        step(); chk("e17.wr_err", 32'(wr_err), 32'd1); chk("e17.tick", 32'(tick), 32'd0);
        wr(0, 0, 1'b0);
        step(); chk("e18.wr_err", 32'(wr_err), 32'd1); chk("e18.tick", 32'(tick), 32'd0);
        wr_en = 1'b0;
        step(); chk("e19.wr_err", 32'(wr_err), 32'd0); chk_out("e19", 4'h2, 4'h0);
        step(); chk_out("e20", 4'hd, 4'h0);

        // ch0 -> div 1 pulse, applied at edge 25; then en low for 3 edges
        wr(0, 1, 1'b0);
        step(); chk_out("e21", 4'h0, 4'h0);
        wr_en = 1'b0;
        step(); step(); step();
        step(); chk_out("e25", 4'hf, 4'h0);
        step(); chk_out("e26", 4'h1, 4'h0);
        en = 1'b0;
        step(); chk_out("e27", 4'h0, 4'h0);
        step(); step(); chk_out("e29", 4'h0, 4'h0);
        en = 1'b1;
        step(); chk_out("e30", 4'h1, 4'h0);
        step(); chk_out("e31", 4'h3, 4'h2);
        step(); chk_out("e32", 4'h1, 4'h2);
        step(); chk_out("e33", 4'hd, 4'h2);

        // Pending ch2 write, then sync together with a ch3 write
        wr(2, 2, 1'b1);
        step(); chk_out("e34", 4'h3, 4'h0);
        sync = 1'b1;
        wr(3, 4, 1'b1);
        step(); chk_out("e35.sync", 4'h0, 4'h0);
        sync = 1'b0; wr_en = 1'b0;
        step(); chk_out("e36", 4'h1, 4'h0);
        step(); chk_out("e37", 4'h5, 4'h4);
        step(); chk_out("e38", 4'h3, 4'h6);
        step(); chk_out("e39", 4'hd, 4'ha);
        step(); chk_out("e40", 4'h1, 4'ha);

        // Write on ch1's wrap edge stays pending; then a rejected write
        wr(1, 2, 1'b1);
        step(); chk_out("e41", 4'h7, 4'hc);
        wr(7, 3, 1'b0);
        step(); chk_out("e42", 4'h1, 4'hc);
        chk("e42.wr_err", 32'(wr_err), 32'd1);

        // Asynchronous reset mid-period, no clock edge
        #3 rst = 1'b1;
        #1;
        chk_out("async_rst", 4'h0, 4'h0);
        chk("async_rst.wr_err", 32'(wr_err), 32'd0);
        wr_en = 1'b0;
        step();
        rst = 1'b0;

        // Divisors back to 5, ch1 pending discarded
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("post_rst.tick", 32'(tick), 32'd0);
        end
        step(); chk_out("post_rst.e5", 4'hf, 4'h0);
        step(); step(); chk_out("post_rst.e7", 4'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
